lfsr_checker: RTL and testbench

Receive-side checker for the 4-bit LFSR pattern generator. It consumes the generator's parallel state word and synchronises to the sequence with a flywheel predictor. It then flags every word that deviates from the predicted next state and counts errors. It sits at the far end of a link or loopback under test. It reports lock status and bit-error events to the test controller.

---
 rtl/lfsr_pkg.sv | 20 ++
 rtl/lfsr_err_counter.sv | 27 ++
 rtl/lfsr_checker.sv | 142 ++++++++++++++
 tb/tb_lfsr_checker.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 4-bit LFSR pattern generator and its receive-side checker.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package lfsr_pkg;

    localparam int LFSR_W = 4;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 4'hE;

    // Checker synchronisation states
    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    // Sequence rule shared with the generator; from the seed the period is 6 (E,C,9,3,7,F)
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[2:0], s[3] ^ s[1]};
    endfunction

endpackage : lfsr_pkg

// File: rtl/lfsr_err_counter.sv
// Saturating error counter with synchronous clear; clear and increment together leave a count of one.
// Latency: count reflects inc/clr one edge after they are presented.
// Backpressure: none; inc and clr are sampled every cycle.
module lfsr_err_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Count register: clear wins over history, but the error arriving with it is kept
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= inc ? W'(1) : '0;
        end else if (inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule : lfsr_err_counter

// File: rtl/lfsr_checker.sv
// Receive-side LFSR checker: flywheel predictor locks to the sequence, flags and counts mispredictions.
// Latency: a sample captured at edge k updates locked_o/err_o/err_cnt_o/exp_o at that same edge (visible cycle k+1).
// Backpressure: none; a valid sample is accepted every cycle. Error counter built only with LFSR_CHECKER_ERR_CNT_EN.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_i,
    input  logic [LFSR_W-1:0] data_i,
    input  logic              clear_i,
    output logic              locked_o,
    output logic              err_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [LFSR_W-1:0] exp_o
);

    // Run counters are 4 bits wide because both thresholds are limited to 1..15
    localparam int          RUN_W     = 4;
    localparam logic [RUN_W-1:0] LOCK_LAST = RUN_W'(LOCK_CNT - 1);
    localparam logic [RUN_W-1:0] LOSS_LAST = RUN_W'(LOSS_CNT - 1);

    chk_state_t        state_q, state_d;
    logic [LFSR_W-1:0] ref_q, ref_d;
    logic              ref_vld_q, ref_vld_d;
    logic [RUN_W-1:0]  match_q, match_d;
    logic [RUN_W-1:0]  miss_q, miss_d;
    logic              err_d;

    logic [LFSR_W-1:0] pred;
    logic              hit;

    // Prediction and match decision; a zero word is a lock-up state and never counts as a match
    always_comb begin
        pred = lfsr_next(ref_q);
        hit  = ref_vld_q && (data_i != '0) && (data_i == pred);
    end

    // Next-state logic: SEARCH re-seeds from received data, LOCKED free-runs the predictor
    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        match_d   = match_q;
        miss_d    = miss_q;
        err_d     = 1'b0;

        if (valid_i) begin
            case (state_q)
                SEARCH: begin
                    if (data_i != '0) begin
                        ref_d     = data_i;
                        ref_vld_d = 1'b1;
                    end
                    if (hit) begin
                        if (match_q == LOCK_LAST) begin
                            state_d = LOCKED;
                            match_d = '0;
                            miss_d  = '0;
                        end else begin
                            match_d = match_q + RUN_W'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: the received word never replaces the reference here
                    ref_d = pred;
                    if (hit) begin
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (miss_q == LOSS_LAST) begin
                            state_d   = SEARCH;
                            miss_d    = '0;
                            match_d   = '0;
                            ref_vld_d = 1'b0;
                        end else begin
                            miss_d = miss_q + RUN_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    // Internal state registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= SEARCH;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
            match_q   <= '0;
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
        end
    end

    // Registered status outputs, driven from the next-state values so they track the state at the same edge
    always_ff @(posedge clk) begin
        if (!reset) begin
            locked_o <= 1'b0;
            err_o    <= 1'b0;
            exp_o    <= '0;
        end else begin
            locked_o <= (state_d == LOCKED);
            err_o    <= err_d;
            exp_o    <= ref_vld_d ? lfsr_next(ref_d) : '0;
        end
    end

`ifdef LFSR_CHECKER_ERR_CNT_EN
    lfsr_err_counter #(
        .W(ERR_W)
    ) u_err_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (err_d),
        .clr   (clear_i),
        .cnt   (err_cnt_o)
    );
`else
    // No counter in this build: the count reads zero and clear has nothing to act on
    logic unused_clear;
    assign unused_clear = clear_i;
    assign err_cnt_o    = '0;
`endif

endmodule : lfsr_checker

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default and ERR_W=2/LOSS_CNT=15) share one stimulus stream.
// A sample-level reference model predicts every output; directed scenarios pin key values.
// Summary line reports comparisons made and comparisons failed.
module tb_lfsr_checker;
    import lfsr_pkg::*;

`ifdef LFSR_CHECKER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int LOCK_N = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid;
    logic [3:0] data;
    logic       clear;

    logic       locked0, err0, locked1, err1;
    logic [7:0] cnt0;
    logic [1:0] cnt1;
    logic [3:0] exp0, exp1;

    int total = 0;
    int bad   = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    lfsr_checker #(.LOCK_CNT(3), .LOSS_CNT(2), .ERR_W(8)) dut0 (
        .clk(clk), .reset(reset), .valid_i(valid), .data_i(data), .clear_i(clear),
        .locked_o(locked0), .err_o(err0), .err_cnt_o(cnt0), .exp_o(exp0)
    );

    lfsr_checker #(.LOCK_CNT(3), .LOSS_CNT(15), .ERR_W(2)) dut1 (
        .clk(clk), .reset(reset), .valid_i(valid), .data_i(data), .clear_i(clear),
        .locked_o(locked1), .err_o(err1), .err_cnt_o(cnt1), .exp_o(exp1)
    );

    // ---------------- reference model (one per instance) ----------------
    int LOSS[2] = '{2, 15};
    int CMAX[2] = '{255, 3};
    int m_lock[2], m_ref[2], m_rv[2], m_mc[2], m_xc[2], m_err[2], m_cnt[2];

    function automatic int m_nxt(input int s);
        return ((s << 1) & 14) | (((s >> 3) ^ (s >> 1)) & 1);
    endfunction

    function automatic int m_exp(input int m);
        return (m_rv[m] != 0) ? m_nxt(m_ref[m]) : 0;
    endfunction

    task automatic model_step(input int m);
        int p;
        bit hit;
        bit e;
        e = 1'b0;
        if (!reset) begin
            m_lock[m] = 0; m_ref[m] = 0; m_rv[m] = 0; m_mc[m] = 0;
            m_xc[m] = 0; m_err[m] = 0; m_cnt[m] = 0;
            return;
        end
        if (valid) begin
            p   = m_nxt(m_ref[m]);
            hit = (m_rv[m] != 0) && (data != 0) && (int'(data) == p);
            if (m_lock[m] == 0) begin
                if (data != 0) begin
                    m_ref[m] = int'(data);
                    m_rv[m]  = 1;
                end
                m_mc[m] = hit ? m_mc[m] + 1 : 0;
                if (m_mc[m] == LOCK_N) begin
                    m_lock[m] = 1; m_mc[m] = 0; m_xc[m] = 0;
                end
            end else begin
                m_ref[m] = p;
                if (hit) begin
                    m_xc[m] = 0;
                end else begin
                    e = 1'b1;
                    m_xc[m]++;
                    if (m_xc[m] == LOSS[m]) begin
                        m_lock[m] = 0; m_rv[m] = 0; m_mc[m] = 0; m_xc[m] = 0;
                    end
                end
            end
        end
        m_err[m] = e;
        if (CNT_EN) begin
            if (clear) m_cnt[m] = e ? 1 : 0;
            else if (e && m_cnt[m] < CMAX[m]) m_cnt[m]++;
        end
    endtask

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) model_step(m);
    end

    task automatic check(input string nm, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    // Every-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("locked0", int'(locked0), m_lock[0]);
            check("err0",    int'(err0),    m_err[0]);
            check("cnt0",    int'(cnt0),    m_cnt[0]);
            check("exp0",    int'(exp0),    m_exp(0));
            check("locked1", int'(locked1), m_lock[1]);
            check("err1",    int'(err1),    m_err[1]);
            check("cnt1",    int'(cnt1),    m_cnt[1]);
            check("exp1",    int'(exp1),    m_exp(1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input int d, input bit c);
        valid = 1'b1; data = 4'(d); clear = c;
        @(negedge clk);
    endtask

    task automatic idle(input bit c);
        valid = 1'b0; clear = c;
        @(negedge clk);
    endtask

    int g;
    int seq[6] = '{12, 9, 3, 7, 15, 14};

    initial begin
        reset = 1'b0; valid = 1'b0; data = 4'h0; clear = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_locked", int'(locked0), 0);
        check("rst_err",    int'(err0),    0);
        check("rst_cnt",    int'(cnt0),    0);
        check("rst_exp",    int'(exp0),    0);
        @(negedge clk);
        reset = 1'b1;

        // Pin the model's sequence rule to the known period-6 cycle
        g = int'(LFSR_SEED);
        for (int i = 0; i < 6; i++) begin
            check("model_seq", m_nxt(g), seq[i]);
            g = m_nxt(g);
        end

        // Clean lock over 20 samples
        g = 14;
        for (int i = 0; i < 20; i++) begin
            send(g, 1'b0);
            if (i == 2) check("lock_early", int'(locked0), 0);
            if (i == 3) check("lock_at_4",  int'(locked0), 1);
            g = m_nxt(g);
        end
        check("clean_cnt", int'(cnt0), 0);

        // Align to the seed, then single error on the 4th word
        while (g != 14) begin send(g, 1'b0); g = m_nxt(g); end
        send(14, 1'b0); send(12, 1'b0); send(9, 1'b0);
        send(11, 1'b0);
        check("single_err",  int'(err0),    1);
        check("single_cnt",  int'(cnt0),    CNT_EN ? 1 : 0);
        check("single_lock", int'(locked0), 1);
        check("single_exp7", int'(exp0),    7);
        send(7, 1'b0);
        check("single_expF", int'(exp0),    15);
        check("single_noerr", int'(err0),   0);
        send(15, 1'b0);
        g = 14;

        // Lock loss after two wrong words
        send(5, 1'b0); g = m_nxt(g);
        check("loss_first_lock", int'(locked0), 1);
        check("loss_first_err",  int'(err0),    1);
        send(5, 1'b0); g = m_nxt(g);
        check("loss_lock", int'(locked0), 0);
        check("loss_cnt",  int'(cnt0),    CNT_EN ? 3 : 0);
        check("loss_exp",  int'(exp0),    0);
        check("loss_keep1", int'(locked1), 1);
        for (int i = 0; i < 4; i++) begin
            send(g, 1'b0); g = m_nxt(g);
            if (i == 2) check("relock_early", int'(locked0), 0);
            if (i == 3) check("relock",       int'(locked0), 1);
        end

        // Reset for one edge while locked, with a sample in flight
        reset = 1'b0;
        send(g, 1'b0);
        reset = 1'b1;
        check("midrst_lock0", int'(locked0), 0);
        check("midrst_exp0",  int'(exp0),    0);
        check("midrst_lock1", int'(locked1), 0);
        check("midrst_cnt1",  int'(cnt1),    0);
        for (int i = 0; i < 4; i++) begin
            send(g, 1'b0); g = m_nxt(g);
            if (i == 2) check("rst_relock_early", int'(locked0), 0);
            if (i == 3) check("rst_relock",       int'(locked0), 1);
        end

        // Zero word in SEARCH restarts the match run
        reset = 1'b0; idle(1'b0); reset = 1'b1;
        send(g, 1'b0); g = m_nxt(g);
        send(g, 1'b0); g = m_nxt(g);
        send(0, 1'b0);
        check("zero_nolock", int'(locked0), 0);
        for (int i = 0; i < 3; i++) begin
            send(g, 1'b0); g = m_nxt(g);
            if (i == 1) check("zero_early", int'(locked0), 0);
            if (i == 2) check("zero_lock",  int'(locked0), 1);
        end

        // Idle gaps inside a locked stream
        for (int i = 0; i < 6; i++) begin
            send(g, 1'b0); g = m_nxt(g);
            idle(1'b0);
            check("gap_exp",  int'(exp0),    g);
            check("gap_err",  int'(err0),    0);
            check("gap_lock", int'(locked0), 1);
        end

        // Saturation on the narrow instance, then clear with and without an error
        for (int i = 0; i < 5; i++) begin
            send(g ^ 6, 1'b0); g = m_nxt(g);
        end
        check("sat_cnt",  int'(cnt1),    CNT_EN ? 3 : 0);
        check("sat_lock", int'(locked1), 1);
        check("sat_err",  int'(err1),    1);
        send(g ^ 6, 1'b1); g = m_nxt(g);
        check("clr_err_cnt", int'(cnt1), CNT_EN ? 1 : 0);
        idle(1'b1);
        check("clr_cnt", int'(cnt1), 0);
        clear = 1'b0;

        // Randomised traffic: gaps, bit errors, zeros, phase slips, clears and rare resets
        for (int i = 0; i < 3000; i++) begin
            int r;
            bit c;
            reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            c = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) begin
                idle(c);
            end else begin
                r = $urandom_range(0, 99);
                if (r < 85)      send(g, c);
                else if (r < 93) send(g ^ (1 << $urandom_range(0, 3)), c);
                else if (r < 96) send(0, c);
                else             send(int'($urandom_range(0, 15)), c);
                g = m_nxt(g);
                if ($urandom_range(0, 49) == 0) g = m_nxt(g);
            end
        end
        reset = 1'b1; valid = 1'b0; clear = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lfsr_checker
